// File: rtl/irq_priority_arbiter_pkg.sv
// Shared types and helpers for the interrupt priority arbiter.
package irq_priority_arbiter_pkg;

    localparam logic ARB_FIXED = 1'b0;
    localparam logic ARB_RR    = 1'b1;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } arb_state_e;

    // Ceiling log2 for elaboration-time width calculation.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned p = 1; p < value; p = p << 1) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/irq_priority_arbiter_if.sv
// Request-side and winner-presentation signals of the interrupt arbiter.
interface irq_priority_arbiter_if
    import irq_priority_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CH = 8,
    parameter int unsigned IDX_W  = clog2(NUM_CH)
);
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] edge_mode;
    logic [NUM_CH-1:0] mask;
    logic              rr_mode_wr;
    logic              rr_mode_in;
    logic              ack;
    logic              irq_valid;
    logic [IDX_W-1:0]  irq_idx;
    logic [NUM_CH-1:0] pending;

    modport master (
        output req, edge_mode, mask, rr_mode_wr, rr_mode_in, ack,
        input  irq_valid, irq_idx, pending
    );

    modport slave (
        input  req, edge_mode, mask, rr_mode_wr, rr_mode_in, ack,
        output irq_valid, irq_idx, pending
    );
endinterface

// File: rtl/irq_priority_arbiter_pick.sv
// Combinational winner search: rotate by start pointer, find lowest set bit, un-rotate.
module rr_priority_pick
    import irq_priority_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CH = 8,
    parameter int unsigned IDX_W  = clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] eligible_i,
    input  logic [IDX_W-1:0]  start_i,
    input  logic              mode_i,
    output logic              any_c_o,
    output logic [IDX_W-1:0]  idx_c_o
);
    localparam int unsigned DW = 2 * NUM_CH;

    logic [DW-1:0]     doubled;
    logic [NUM_CH-1:0] rotated;
    logic [IDX_W-1:0]  start;
    logic [IDX_W-1:0]  lsb;
    logic [IDX_W:0]    sum;

    always_comb begin
        start   = (mode_i == ARB_RR) ? start_i : '0;
        doubled = {eligible_i, eligible_i} >> start;
        rotated = doubled[NUM_CH-1:0];
        any_c_o = |rotated;

        lsb = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                lsb = IDX_W'(i);
            end
        end

        // Modulo-NUM_CH add so non-power-of-two channel counts wrap correctly.
        sum = {1'b0, lsb} + {1'b0, start};
        if (sum >= (IDX_W+1)'(NUM_CH)) begin
            sum = sum - (IDX_W+1)'(NUM_CH);
        end
        idx_c_o = sum[IDX_W-1:0];
    end
endmodule

// File: rtl/irq_priority_arbiter.sv
// Pending-latch interrupt arbiter with fixed/round-robin selection and valid/ack presentation.
module irq_priority_arbiter
    import irq_priority_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CH   = 8,
    parameter int unsigned IDX_W    = clog2(NUM_CH),
    parameter bit          RR_RESET = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    irq_priority_arbiter_if.slave bus
);
    arb_state_e        state_q;
    logic [NUM_CH-1:0] pending_q;
    logic [NUM_CH-1:0] pending_d;
    logic [NUM_CH-1:0] req_prev_q;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  rr_ptr_q;
    logic [IDX_W-1:0]  rr_ptr_d;
    logic              rr_mode_q;
    logic              rr_mode_d;

    logic [NUM_CH-1:0] set_c;
    logic [NUM_CH-1:0] clr_c;
    logic [NUM_CH-1:0] sel_c;
    logic [NUM_CH-1:0] eligible_c;
    logic              accept_c;
    logic              hold_ok_c;
    logic              win_any_c;
    logic [IDX_W-1:0]  win_idx_c;

    always_comb begin
        accept_c = (state_q == ST_PRESENT) && bus.ack;

        for (int i = 0; i < int'(NUM_CH); i++) begin
            sel_c[i] = (idx_q == IDX_W'(i));
        end

        // Edge channels set on a 0->1 transition, level channels whenever req is high.
        set_c      = (bus.edge_mode & bus.req & ~req_prev_q) | (~bus.edge_mode & bus.req);
        clr_c      = accept_c ? sel_c : '0;
        pending_d  = set_c | (pending_q & ~clr_c);
        eligible_c = pending_q & ~bus.mask;
        hold_ok_c  = |(eligible_c & sel_c);

        rr_ptr_d = rr_ptr_q;
        if (accept_c) begin
            rr_ptr_d = (idx_q == IDX_W'(NUM_CH - 1)) ? '0 : idx_q + IDX_W'(1);
        end

        rr_mode_d = bus.rr_mode_wr ? bus.rr_mode_in : rr_mode_q;
    end

    rr_priority_pick #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_pick (
        .eligible_i (eligible_c),
        .start_i    (rr_ptr_q),
        .mode_i     (rr_mode_q),
        .any_c_o    (win_any_c),
        .idx_c_o    (win_idx_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            req_prev_q <= '0;
            idx_q      <= '0;
            rr_ptr_q   <= '0;
            rr_mode_q  <= RR_RESET;
        end else begin
            pending_q  <= pending_d;
            req_prev_q <= bus.req;
            rr_ptr_q   <= rr_ptr_d;
            rr_mode_q  <= rr_mode_d;
            case (state_q)
                ST_IDLE: begin
                    if (win_any_c) begin
                        idx_q   <= win_idx_c;
                        state_q <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    // Leave on acceptance, or withdraw if the held channel is no longer eligible.
                    if (accept_c || !hold_ok_c) begin
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.irq_valid = (state_q == ST_PRESENT);
    assign bus.irq_idx   = idx_q;
    assign bus.pending   = pending_q;
endmodule

// File: tb/tb_irq_priority_arbiter.sv
// Directed vector table plus randomized run against a behavioural model, NUM_CH=8.
module tb_irq_priority_arbiter;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst;

    irq_priority_arbiter_if #(.NUM_CH(8), .IDX_W(3)) bus();

    irq_priority_arbiter #(.NUM_CH(8), .IDX_W(3), .RR_RESET(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic [7:0] edge_m;
        logic [7:0] mask;
        logic       rr_wr;
        logic       rr_in;
        logic       ack;
        logic       exp_valid;
        logic [2:0] exp_idx;
        logic [7:0] exp_pend;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_err = 0;

    bit [7:0] m_pend;
    bit [7:0] m_reqp;
    bit       m_valid;
    int       m_idx;
    int       m_ptr;
    bit       m_mode;

    task automatic add(input logic r, input logic [7:0] rq, input logic [7:0] em, input logic [7:0] mk,
                       input logic rw, input logic ri, input logic ak,
                       input logic ev, input logic [2:0] ei, input logic [7:0] ep);
        vec_t v;
        v.rst = r; v.req = rq; v.edge_m = em; v.mask = mk;
        v.rr_wr = rw; v.rr_in = ri; v.ack = ak;
        v.exp_valid = ev; v.exp_idx = ei; v.exp_pend = ep;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        rst            = v.rst;
        bus.req        = v.req;
        bus.edge_mode  = v.edge_m;
        bus.mask       = v.mask;
        bus.rr_mode_wr = v.rr_wr;
        bus.rr_mode_in = v.rr_in;
        bus.ack        = v.ack;
    endtask

    // Next-state of the arbiter computed directly from the channel rules.
    task automatic model_edge(input vec_t s);
        bit [7:0] elig;
        bit [7:0] np;
        int       win;
        int       start;
        bit       acc;
        bit       set_b;
        if (s.rst) begin
            m_pend = '0; m_reqp = '0; m_valid = 1'b0; m_idx = 0; m_ptr = 0; m_mode = 1'b0;
            return;
        end
        elig  = m_pend & ~s.mask;
        start = m_mode ? m_ptr : 0;
        win   = -1;
        for (int k = 0; k < N; k++) begin
            int c;
            c = (start + k) % N;
            if (elig[c] && win < 0) win = c;
        end
        acc = m_valid && s.ack;
        for (int i = 0; i < N; i++) begin
            set_b = s.edge_m[i] ? (s.req[i] && !m_reqp[i]) : s.req[i];
            np[i] = set_b || (m_pend[i] && !(acc && m_idx == i));
        end
        if (acc) m_ptr = (m_idx + 1) % N;
        if (!m_valid) begin
            if (win >= 0) begin
                m_valid = 1'b1;
                m_idx   = win;
            end
        end else if (acc || !elig[m_idx]) begin
            m_valid = 1'b0;
        end
        if (s.rr_wr) m_mode = s.rr_in;
        m_pend = np;
        m_reqp = s.req;
    endtask

    initial begin
        vec_t s;

        // rst req   edge  mask  rw ri ak  valid idx pending
        add(0, 8'h20, 8'hFF, 8'h00, 0, 0, 0, 0, 3'd0, 8'h20);
        add(0, 8'h00, 8'hFF, 8'h00, 0, 0, 0, 1, 3'd5, 8'h20);
        add(0, 8'h00, 8'hFF, 8'h00, 0, 0, 1, 0, 3'd5, 8'h00);
        add(0, 8'h00, 8'hFF, 8'h00, 0, 0, 0, 0, 3'd5, 8'h00);
        add(0, 8'h90, 8'hFF, 8'h00, 0, 0, 0, 0, 3'd5, 8'h90);
        add(0, 8'h90, 8'hFF, 8'h00, 0, 0, 0, 1, 3'd4, 8'h90);
        add(0, 8'h91, 8'hFF, 8'h00, 0, 0, 0, 1, 3'd4, 8'h91);
        add(0, 8'h90, 8'hFF, 8'h00, 0, 0, 0, 1, 3'd4, 8'h91);
        add(0, 8'h00, 8'hFF, 8'h00, 0, 0, 1, 0, 3'd4, 8'h81);
        add(0, 8'h00, 8'hFF, 8'h00, 0, 0, 0, 1, 3'd0, 8'h81);
        add(0, 8'h00, 8'hFF, 8'h00, 0, 0, 1, 0, 3'd0, 8'h80);
        add(0, 8'h00, 8'hFF, 8'h00, 0, 0, 0, 1, 3'd7, 8'h80);
        add(0, 8'h00, 8'hFF, 8'h00, 0, 0, 1, 0, 3'd7, 8'h00);
        add(0, 8'h00, 8'hFF, 8'h00, 0, 0, 1, 0, 3'd7, 8'h00);
        // round-robin, level channels 0..2 held
        add(0, 8'h07, 8'h00, 8'h00, 1, 1, 0, 0, 3'd7, 8'h07);
        add(0, 8'h07, 8'h00, 8'h00, 0, 0, 0, 1, 3'd0, 8'h07);
        add(0, 8'h07, 8'h00, 8'h00, 0, 0, 1, 0, 3'd0, 8'h07);
        add(0, 8'h07, 8'h00, 8'h00, 0, 0, 0, 1, 3'd1, 8'h07);
        add(0, 8'h07, 8'h00, 8'h00, 0, 0, 1, 0, 3'd1, 8'h07);
        add(0, 8'h07, 8'h00, 8'h00, 0, 0, 0, 1, 3'd2, 8'h07);
        add(0, 8'h07, 8'h00, 8'h00, 0, 0, 1, 0, 3'd2, 8'h07);
        add(0, 8'h07, 8'h00, 8'h00, 0, 0, 0, 1, 3'd0, 8'h07);
        add(0, 8'h07, 8'h00, 8'h00, 0, 0, 1, 0, 3'd0, 8'h07);
        add(0, 8'h00, 8'h00, 8'h00, 0, 0, 1, 1, 3'd1, 8'h07);
        // reset while presenting with ack
        add(1, 8'h00, 8'h00, 8'h00, 0, 0, 1, 0, 3'd0, 8'h00);
        // mask handling and withdrawal
        add(0, 8'h0C, 8'hFF, 8'h04, 0, 0, 0, 0, 3'd0, 8'h0C);
        add(0, 8'h00, 8'hFF, 8'h04, 0, 0, 0, 1, 3'd3, 8'h0C);
        add(0, 8'h00, 8'hFF, 8'h0C, 0, 0, 0, 0, 3'd3, 8'h0C);
        add(0, 8'h00, 8'hFF, 8'h0C, 0, 0, 0, 0, 3'd3, 8'h0C);
        add(0, 8'h00, 8'hFF, 8'h00, 0, 0, 0, 1, 3'd2, 8'h0C);
        // req held high across reset release counts as an edge
        add(1, 8'h01, 8'hFF, 8'h00, 0, 0, 0, 0, 3'd0, 8'h00);
        add(0, 8'h01, 8'hFF, 8'h00, 0, 0, 0, 0, 3'd0, 8'h01);
        add(0, 8'h01, 8'hFF, 8'h00, 0, 0, 0, 1, 3'd0, 8'h01);

        s = '{rst: 1'b1, req: 8'h00, edge_m: 8'hFF, mask: 8'h00, rr_wr: 1'b0, rr_in: 1'b0,
              ack: 1'b0, exp_valid: 1'b0, exp_idx: 3'd0, exp_pend: 8'h00};
        drive(s);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 32'(bus.irq_valid), 32'd0);
        chk("reset_idx",   32'(bus.irq_idx),   32'd0);
        chk("reset_pend",  32'(bus.pending),   32'd0);

        foreach (tbl[i]) begin
            drive(tbl[i]);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_valid", i), 32'(bus.irq_valid), 32'(tbl[i].exp_valid));
            chk($sformatf("vec%0d_idx", i),   32'(bus.irq_idx),   32'(tbl[i].exp_idx));
            chk($sformatf("vec%0d_pend", i),  32'(bus.pending),   32'(tbl[i].exp_pend));
        end

        for (int c = 0; c < 3000; c++) begin
            s.rst    = (c == 0) || ($urandom_range(0, 99) == 0);
            s.req    = 8'($urandom) & 8'($urandom);
            s.edge_m = 8'($urandom);
            s.mask   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            s.rr_wr  = ($urandom_range(0, 15) == 0);
            s.rr_in  = 1'($urandom);
            s.ack    = 1'($urandom);
            drive(s);
            model_edge(s);
            @(posedge clk);
            #1;
            chk("rand_valid", 32'(bus.irq_valid), 32'(m_valid));
            chk("rand_idx",   32'(bus.irq_idx),   32'(m_idx));
            chk("rand_pend",  32'(bus.pending),   32'(m_pend));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/irq_priority_arbiter.md
Name: irq_priority_arbiter

Overview:
- Registered, parametrised successor to the 8-bit combinational priority encoder.
- Latches per-channel interrupt/service requests into a pending register, applies a mask, and selects one winner. Selection uses either fixed priority or round-robin.
- Presents the winner on a valid/ack handshake with a stable index.
- Sits between peripheral request lines (SIO, PIA, timers) and the host-side service sequencer.

Parameters:
- NUM_CH, 8: number of request channels (2..32).
- IDX_W, $clog2(NUM_CH): width of the winner index.
- RR_RESET, 0: reset value of the rr_mode register (0 = fixed, 1 = round-robin).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_CH  raw request lines, synchronous to clk.
- edge_mode  in  NUM_CH  per channel: 1 = rising-edge triggered, 0 = level triggered.
- mask  in  NUM_CH  per channel: 1 = channel not eligible for selection; pending still latches.
- rr_mode_wr  in  1  load rr_mode from rr_mode_in this cycle.
- rr_mode_in  in  1  new arbitration mode.
- ack  in  1  consumer accepts the presented winner.
- irq_valid  out  1  winner is presented on irq_idx.
- irq_idx  out  IDX_W  index of the presented winner.
- pending  out  NUM_CH  registered pending vector, for status reads.

Behaviour:
- Reset (rst high at clk edge) clears the following registers: pending=0, req_d=0, irq_valid=0, irq_idx=0, rr_ptr=0, rr_mode=RR_RESET.
- Because req_d resets to 0, a req already high when reset is released counts as a rising edge.
- set[i] = edge_mode[i] ? (req[i] & ~req_d[i]) : req[i]. req_d <= req every cycle.
- clr[i] = ack & irq_valid & (irq_idx == i).
- pending[i] <= set[i] | (pending[i] & ~clr[i]).
  - If set and clr hit the same channel in the same cycle, set wins.
  - A level channel whose req is still high therefore stays pending after ack.
- eligible = pending & ~mask, using the registered pending value.
- Fixed mode: the lowest index among eligible channels wins.
- Round-robin mode: search starts at rr_ptr and wraps NUM_CH-1 -> 0; the first eligible channel wins.
- rr_ptr update:
  - On each accepted ack, rr_ptr <= irq_idx+1, wrapping to 0 at NUM_CH.
  - rr_ptr is updated in both modes, so switching modes needs no fix-up.
- Presentation state machine, two states:
  - IDLE (irq_valid=0): if eligible != 0, load irq_idx <= winner and go to PRESENT.
  - PRESENT (irq_valid=1): irq_idx is held stable. Higher-priority arrivals do not pre-empt it.
  - PRESENT, ack=1: go to IDLE. The pending bit clears on the same edge.
  - PRESENT, presented channel becomes masked or pending is lost: withdraw and go to IDLE. pending is kept.
- ack while irq_valid=0 is ignored and has no side effects.
- Latency:
  - req edge sampled at edge k -> pending set at edge k -> irq_valid high after edge k+1.
  - After an accepted ack, the next winner is presented no earlier than 2 edges later; one IDLE cycle is guaranteed.
- rr_mode_wr takes effect on the next selection made in IDLE. It never changes a winner that is already presented.
- rst mid-handshake: all state is cleared. Any ack in the same cycle is ignored.
- The winner is only ever an eligible channel, so no invalid index can be presented. irq_idx keeps its last value when irq_valid=0.

Decomposition:
- Shared package:
  - mode constants ARB_FIXED=0, ARB_RR=1.
  - state encoding ST_IDLE/ST_PRESENT.
  - the clog2 helper.
- Sub-module rr_priority_pick: combinational and parametrised by NUM_CH.
  - Inputs: eligible vector, start pointer, mode.
  - Outputs: any, index.
  - Implemented as a rotate, a lowest-set-bit encoder, and an un-rotate. Fixed mode forces start=0.

Test Plan (NUM_CH=8):
- All channels edge mode, mask=0, fixed mode: pulse req=8'h20 for one cycle -> pending=8'h20; irq_valid=1, irq_idx=5 two edges after the pulse; ack -> pending=0, irq_valid=0.
- Fixed mode, set req=8'h90 together -> channel 4 presented. While holding, pulse req[0] -> irq_idx stays 4. ack -> IDLE cycle, then idx 0; ack -> idx 7.
- Round-robin mode, level mode on all channels, req=8'h07 held: four successive acks present 0,1,2,0. pending stays 8'h07 because set beats clr.
- Mask: pending=8'h0C, mask=8'h04 -> idx 3 presented. Mask bit 3 while presented -> irq_valid drops next edge, pending still 8'h0C, no grant issued.
- Ack while irq_valid=0 -> no change to pending or rr_ptr. Asserting rst during PRESENT with ack=1 -> all outputs 0 on the next edge.
- req high across reset release with edge mode -> pending bit sets on the first edge after rst drops.
